// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path: FSM states,
// opcodes, and the datapath mux/ALU/extender select codes.
package multicycle_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    EXEC_R    = 4'd3,
    R_WB      = 4'd4,
    EXEC_I    = 4'd5,
    I_WB      = 4'd6,
    MEM_ADDR  = 4'd7,
    MEM_READ  = 4'd8,
    MEM_WB    = 4'd9,
    MEM_WRITE = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic EXT_SIGN = 1'b0;
  localparam logic EXT_ZERO = 1'b1;

  // ori is the only immediate op that zero-extends and ORs.
  function automatic logic is_ori(input logic [5:0] op);
    return op == OP_ORI;
  endfunction

endpackage

// File: rtl/ctrl_perf_cnt.sv
// Cycle and retired-instruction counters for the multi-cycle controller;
// both wrap modulo 2^CNT_W.
module ctrl_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             active_i,
  input  logic             done_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (active_i) cycle_cnt_d = cycle_cnt_q + 1'b1;
    if (done_i)   instr_cnt_d = instr_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instr_cnt_o = instr_cnt_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS-subset CPU. Defining
// MULTICYCLE_CTRL_PERF_EN adds cycle/instruction counter outputs.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [5:0]         op_i,
  input  logic               zero_i,
  input  logic               mem_ready_i,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic               i_or_d_o,
  output logic               ir_write_o,
  output logic               pc_write_o,
  output logic [1:0]         pc_src_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         alu_op_o,
  output logic               ext_sel_o,
  output logic               reg_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               instr_done_o,
  output logic               illegal_o,
  output logic [STATE_W-1:0] state_o
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   cycle_cnt_o,
  output logic [CNT_W-1:0]   instr_cnt_o
`endif
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;

  // Opcode is latched in DECODE so later states do not depend on IR timing.
  always_comb begin
    op_d = op_q;
    if (state_q == DECODE) op_d = op_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    i_or_d_o     = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = PC_ALU;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_RT;
    alu_op_o     = ALU_ADD;
    ext_sel_o    = EXT_SIGN;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = DECODE;
        end
      end

      DECODE: begin
        alu_src_b_o = SRCB_IMM_SH2;
        case (op_i)
          OP_RTYPE:     state_d = EXEC_R;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI,
          OP_ORI:       state_d = EXEC_I;
          default: begin
            illegal_o    = 1'b1;
            instr_done_o = 1'b1;
            state_d      = FETCH;
          end
        endcase
      end

      EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
        state_d     = R_WB;
      end

      R_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = 1'b1;
        instr_done_o = 1'b1;
        state_d      = FETCH;
      end

      EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        ext_sel_o   = is_ori(op_q) ? EXT_ZERO : EXT_SIGN;
        alu_op_o    = is_ori(op_q) ? ALU_OR : ALU_ADD;
        state_d     = I_WB;
      end

      I_WB: begin
        ext_sel_o    = is_ori(op_q) ? EXT_ZERO : EXT_SIGN;
        alu_op_o     = is_ori(op_q) ? ALU_OR : ALU_ADD;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        state_d      = FETCH;
      end

      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        state_d     = (op_q == OP_SW) ? MEM_WRITE : MEM_READ;
      end

      MEM_READ: begin
        mem_req_o = 1'b1;
        i_or_d_o  = 1'b1;
        if (mem_ready_i) state_d = MEM_WB;
      end

      MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        instr_done_o = 1'b1;
        state_d      = FETCH;
      end

      MEM_WRITE: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        i_or_d_o  = 1'b1;
        if (mem_ready_i) begin
          instr_done_o = 1'b1;
          state_d      = FETCH;
        end
      end

      BRANCH: begin
        alu_src_a_o  = 1'b1;
        alu_op_o     = ALU_SUB;
        pc_src_o     = PC_ALUOUT;
        pc_write_o   = zero_i;
        instr_done_o = 1'b1;
        state_d      = FETCH;
      end

      JUMP: begin
        pc_src_o     = PC_JUMP;
        pc_write_o   = 1'b1;
        instr_done_o = 1'b1;
        state_d      = FETCH;
      end

      default: state_d = IDLE;
    endcase
  end

  assign state_o = STATE_W'(state_q);

`ifdef MULTICYCLE_CTRL_PERF_EN
  ctrl_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .active_i    (state_q != IDLE),
    .done_i      (instr_done_o),
    .cycle_cnt_o (cycle_cnt_o),
    .instr_cnt_o (instr_cnt_o)
  );
`else
  // Counter width only matters when the counters exist.
  logic perf_unused;
  assign perf_unused = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// the FSM and checks states and datapath selects cycle by cycle.
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [5:0] op_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       mem_req_o, mem_we_o, i_or_d_o, ir_write_o, pc_write_o;
  logic [1:0] pc_src_o, alu_src_b_o, alu_op_o;
  logic       alu_src_a_o, ext_sel_o, reg_write_o, reg_dst_o, mem_to_reg_o;
  logic       instr_done_o, illegal_o;
  logic [3:0] state_o;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt_o, instr_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [18:0] all_outs;
  assign all_outs = {mem_req_o, mem_we_o, i_or_d_o, ir_write_o, pc_write_o, pc_src_o,
                     alu_src_a_o, alu_src_b_o, alu_op_o, ext_sel_o, reg_write_o,
                     reg_dst_o, mem_to_reg_o, instr_done_o, illegal_o};

  multicycle_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .op_i         (op_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .i_or_d_o     (i_or_d_o),
    .ir_write_o   (ir_write_o),
    .pc_write_o   (pc_write_o),
    .pc_src_o     (pc_src_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .ext_sel_o    (ext_sel_o),
    .reg_write_o  (reg_write_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .instr_done_o (instr_done_o),
    .illegal_o    (illegal_o),
    .state_o      (state_o)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt_o  (cycle_cnt_o),
    .instr_cnt_o  (instr_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs sampled 1 ns later.
  task automatic adv(input logic rdy, input logic z, input logic [5:0] op);
    @(negedge clk);
    mem_ready_i = rdy;
    zero_i      = z;
    op_i        = op;
    #1;
  endtask

  initial begin
    rst_i = 1'b0; op_i = 6'h00; zero_i = 1'b0; mem_ready_i = 1'b0;

    // Reset held three cycles
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", 32'(state_o), 32'(IDLE));
    chk("rst_outs", 32'(all_outs), 32'h0);

    // Release with mem_ready high: must be ignored, still IDLE this cycle
    @(negedge clk);
    rst_i = 1'b1; mem_ready_i = 1'b1;
    #1;
    chk("rel_state", 32'(state_o), 32'(IDLE));
    chk("rel_outs", 32'(all_outs), 32'h0);

    // R-type with fetch wait of 3 cycles
    for (int i = 0; i < 4; i++) begin
      adv(i == 3, 1'b0, OP_RTYPE);
      $display("fetch wait cycle %0d: state=%0d req=%0b irw=%0b", i, state_o, mem_req_o, ir_write_o);
      chk($sformatf("fw%0d_state", i), 32'(state_o), 32'(FETCH));
      chk($sformatf("fw%0d_req", i), 32'(mem_req_o), 32'(1));
      chk($sformatf("fw%0d_irw", i), 32'(ir_write_o), 32'(i == 3));
      chk($sformatf("fw%0d_pcw", i), 32'(pc_write_o), 32'(i == 3));
      chk($sformatf("fw%0d_srcb", i), 32'(alu_src_b_o), 32'(2'b01));
    end
    adv(1'b0, 1'b0, OP_RTYPE);
    chk("r_dec_state", 32'(state_o), 32'(DECODE));
    chk("r_dec_srcb", 32'(alu_src_b_o), 32'(2'b11));
    adv(1'b1, 1'b0, OP_RTYPE);
    chk("r_ex_state", 32'(state_o), 32'(EXEC_R));
    chk("r_ex_aluop", 32'(alu_op_o), 32'(2'b10));
    chk("r_ex_srca", 32'(alu_src_a_o), 32'(1));
    chk("r_ex_req", 32'(mem_req_o), 32'(0));
    adv(1'b0, 1'b0, OP_RTYPE);
    $display("R-type wb: state=%0d regw=%0b done=%0b", state_o, reg_write_o, instr_done_o);
    chk("r_wb_state", 32'(state_o), 32'(R_WB));
    chk("r_wb_regw", 32'(reg_write_o), 32'(1));
    chk("r_wb_dst", 32'(reg_dst_o), 32'(1));
    chk("r_wb_done", 32'(instr_done_o), 32'(1));

    // lw, memory ready immediately: 5 cycles
    adv(1'b1, 1'b0, OP_LW);
    chk("lw_fetch", 32'(state_o), 32'(FETCH));
    chk("lw_fetch_done", 32'(instr_done_o), 32'(0));
    adv(1'b0, 1'b0, OP_LW);
    chk("lw_dec", 32'(state_o), 32'(DECODE));
    adv(1'b0, 1'b0, OP_LW);
    chk("lw_addr", 32'(state_o), 32'(MEM_ADDR));
    chk("lw_addr_ext", 32'(ext_sel_o), 32'(0));
    chk("lw_addr_srcb", 32'(alu_src_b_o), 32'(2'b10));
    adv(1'b1, 1'b0, OP_LW);
    chk("lw_rd", 32'(state_o), 32'(MEM_READ));
    chk("lw_rd_iord", 32'(i_or_d_o), 32'(1));
    chk("lw_rd_we", 32'(mem_we_o), 32'(0));
    adv(1'b0, 1'b0, OP_LW);
    $display("lw wb: state=%0d m2r=%0b regw=%0b", state_o, mem_to_reg_o, reg_write_o);
    chk("lw_wb", 32'(state_o), 32'(MEM_WB));
    chk("lw_wb_m2r", 32'(mem_to_reg_o), 32'(1));
    chk("lw_wb_regw", 32'(reg_write_o), 32'(1));
    chk("lw_wb_done", 32'(instr_done_o), 32'(1));

    // sw with one wait cycle on the write
    adv(1'b1, 1'b0, OP_SW);
    adv(1'b0, 1'b0, OP_SW);
    adv(1'b0, 1'b0, OP_SW);
    chk("sw_addr", 32'(state_o), 32'(MEM_ADDR));
    adv(1'b0, 1'b0, OP_SW);
    chk("sw_wr0", 32'(state_o), 32'(MEM_WRITE));
    chk("sw_wr0_we", 32'(mem_we_o), 32'(1));
    chk("sw_wr0_done", 32'(instr_done_o), 32'(0));
    adv(1'b1, 1'b0, OP_SW);
    $display("sw write ack: state=%0d we=%0b done=%0b", state_o, mem_we_o, instr_done_o);
    chk("sw_wr1", 32'(state_o), 32'(MEM_WRITE));
    chk("sw_wr1_done", 32'(instr_done_o), 32'(1));

    // beq taken
    adv(1'b1, 1'b0, OP_BEQ);
    chk("beq1_fetch", 32'(state_o), 32'(FETCH));
    adv(1'b0, 1'b0, OP_BEQ);
    adv(1'b0, 1'b1, OP_BEQ);
    $display("beq taken: state=%0d pcw=%0b pcsrc=%0d", state_o, pc_write_o, pc_src_o);
    chk("beq1_state", 32'(state_o), 32'(BRANCH));
    chk("beq1_pcw", 32'(pc_write_o), 32'(1));
    chk("beq1_pcsrc", 32'(pc_src_o), 32'(2'b01));
    chk("beq1_aluop", 32'(alu_op_o), 32'(2'b01));
    chk("beq1_done", 32'(instr_done_o), 32'(1));

    // beq not taken
    adv(1'b1, 1'b0, OP_BEQ);
    chk("beq0_fetch", 32'(state_o), 32'(FETCH));
    adv(1'b0, 1'b0, OP_BEQ);
    adv(1'b0, 1'b0, OP_BEQ);
    $display("beq not taken: state=%0d pcw=%0b", state_o, pc_write_o);
    chk("beq0_state", 32'(state_o), 32'(BRANCH));
    chk("beq0_pcw", 32'(pc_write_o), 32'(0));
    chk("beq0_done", 32'(instr_done_o), 32'(1));

    // j
    adv(1'b1, 1'b0, OP_J);
    adv(1'b0, 1'b0, OP_J);
    adv(1'b0, 1'b0, OP_J);
    $display("j: state=%0d pcsrc=%0d pcw=%0b", state_o, pc_src_o, pc_write_o);
    chk("j_state", 32'(state_o), 32'(JUMP));
    chk("j_pcsrc", 32'(pc_src_o), 32'(2'b10));
    chk("j_pcw", 32'(pc_write_o), 32'(1));

    // ori; op_i changes after DECODE to show the latched opcode is used
    adv(1'b1, 1'b0, OP_ORI);
    adv(1'b0, 1'b0, OP_ORI);
    chk("ori_dec_ext", 32'(ext_sel_o), 32'(0));
    adv(1'b0, 1'b0, OP_RTYPE);
    chk("ori_ex", 32'(state_o), 32'(EXEC_I));
    chk("ori_ex_ext", 32'(ext_sel_o), 32'(1));
    chk("ori_ex_aluop", 32'(alu_op_o), 32'(2'b11));
    chk("ori_ex_srcb", 32'(alu_src_b_o), 32'(2'b10));
    adv(1'b0, 1'b0, OP_RTYPE);
    $display("ori wb: state=%0d ext=%0b aluop=%0d regw=%0b", state_o, ext_sel_o, alu_op_o, reg_write_o);
    chk("ori_wb", 32'(state_o), 32'(I_WB));
    chk("ori_wb_ext", 32'(ext_sel_o), 32'(1));
    chk("ori_wb_aluop", 32'(alu_op_o), 32'(2'b11));
    chk("ori_wb_dst", 32'(reg_dst_o), 32'(0));
    chk("ori_wb_regw", 32'(reg_write_o), 32'(1));

    // addi; op_i switched to ori after DECODE
    adv(1'b1, 1'b0, OP_ADDI);
    adv(1'b0, 1'b0, OP_ADDI);
    adv(1'b0, 1'b0, OP_ORI);
    chk("addi_ex", 32'(state_o), 32'(EXEC_I));
    chk("addi_ex_ext", 32'(ext_sel_o), 32'(0));
    chk("addi_ex_aluop", 32'(alu_op_o), 32'(2'b00));
    adv(1'b0, 1'b0, OP_ORI);
    $display("addi wb: state=%0d ext=%0b aluop=%0d", state_o, ext_sel_o, alu_op_o);
    chk("addi_wb_ext", 32'(ext_sel_o), 32'(0));
    chk("addi_wb_done", 32'(instr_done_o), 32'(1));

    // Illegal opcode
    adv(1'b1, 1'b0, 6'h3F);
    adv(1'b0, 1'b0, 6'h3F);
    $display("illegal: state=%0d illegal=%0b done=%0b", state_o, illegal_o, instr_done_o);
    chk("ill_state", 32'(state_o), 32'(DECODE));
    chk("ill_flag", 32'(illegal_o), 32'(1));
    chk("ill_done", 32'(instr_done_o), 32'(1));
    chk("ill_regw", 32'(reg_write_o), 32'(0));
    chk("ill_pcw", 32'(pc_write_o), 32'(0));
    adv(1'b0, 1'b0, OP_LW);
    chk("ill_next", 32'(state_o), 32'(FETCH));
    chk("ill_next_flag", 32'(illegal_o), 32'(0));
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("perf_instr9", instr_cnt_o, 32'd9);
`endif

    // Reset asserted in MEM_READ
    adv(1'b1, 1'b0, OP_LW);
    adv(1'b0, 1'b0, OP_LW);
    adv(1'b0, 1'b0, OP_LW);
    adv(1'b0, 1'b0, OP_LW);
    chk("mr_state", 32'(state_o), 32'(MEM_READ));
    @(negedge clk);
    rst_i = 1'b0; mem_ready_i = 1'b1;
    #1;
    $display("reset in MEM_READ: state=%0d regw=%0b", state_o, reg_write_o);
    chk("mr_rst_state", 32'(state_o), 32'(IDLE));
    chk("mr_rst_outs", 32'(all_outs), 32'h0);
    @(negedge clk);
    #1;
    chk("mr_rst_hold", 32'(state_o), 32'(IDLE));
    chk("mr_rst_regw", 32'(reg_write_o), 32'(0));
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("perf_rst_instr", instr_cnt_o, 32'd0);
    chk("perf_rst_cycle", cycle_cnt_o, 32'd0);
`endif
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("mr_rel_state", 32'(state_o), 32'(IDLE));
    adv(1'b0, 1'b0, OP_RTYPE);
    chk("mr_rel_fetch", 32'(state_o), 32'(FETCH));
    chk("mr_rel_irw", 32'(ir_write_o), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
